// File: rtl/idct_block_sequencer_pkg.sv
// Shared constants and FSM encoding for the frame-level iDCT block sequencer.
package idct_block_sequencer_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_LD      = 4'd1;
  localparam state_t S_WAIT_LD = 4'd2;
  localparam state_t S_XF      = 4'd3;
  localparam state_t S_WAIT_XF = 4'd4;
  localparam state_t S_ST      = 4'd5;
  localparam state_t S_WAIT_ST = 4'd6;
  localparam state_t S_NEXT    = 4'd7;
  localparam state_t S_FIN     = 4'd8;
  localparam state_t S_ERR     = 4'd9;

  localparam int BLK_WORDS      = 64;
  localparam int BLK_SHIFT      = 6;
  localparam int IDX_W          = 12;
  localparam int DEF_NUM_BLOCKS = 4096;
  localparam int DEF_TIMEOUT    = 1024;

endpackage

// File: rtl/idct_block_sequencer_if.sv
// Per-phase start/done handshakes and block base addresses.
interface idct_block_sequencer_if #(
  parameter int AW = 18
);

  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_done;
  logic          idct_start;
  logic          idct_done;
  logic          st_start;
  logic [AW-1:0] st_base;
  logic          st_done;

  modport master (
    output ld_start, ld_base,
    output idct_start,
    output st_start, st_base,
    input  ld_done, idct_done, st_done
  );

  modport slave (
    input  ld_start, ld_base,
    input  idct_start,
    input  st_start, st_base,
    output ld_done, idct_done, st_done
  );

endinterface

// File: rtl/idct_block_sequencer_phase_watchdog.sv
// Wait-cycle counter; flags the last allowed cycle of a phase wait.
module idct_block_sequencer_phase_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High in the cycle whose count makes TIMEOUT waited cycles.
  assign o_tc = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/idct_block_sequencer.sv
// Frame sequencer: load -> iDCT -> store for each 8x8 block,
// with block address generation and a per-phase watchdog.
module idct_block_sequencer
  import idct_block_sequencer_pkg::*;
#(
  parameter int AW         = 18,
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [IDX_W-1:0]       blk_idx,
  idct_block_sequencer_if.master phase
);

  state_t           r_state;
  state_t           w_nxt;
  logic [IDX_W-1:0] r_blk;
  logic [IDX_W-1:0] w_blk_inc;
  logic [AW-1:0]    r_base;
  logic             w_wait;
  logic             w_tc;
  logic             w_last;
  logic             w_go;

  assign w_wait = (r_state == S_WAIT_LD) ||
                  (r_state == S_WAIT_XF) ||
                  (r_state == S_WAIT_ST);
  assign w_last = (r_blk == IDX_W'(NUM_BLOCKS - 1));
  assign w_go   = start &&
                  ((r_state == S_IDLE) || (r_state == S_ERR));
  assign w_blk_inc = r_blk + 1'b1;

  idct_block_sequencer_phase_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clock (clock),
    .rst_n (rst_n),
    .i_clr (!w_wait),
    .i_en  (w_wait),
    .o_tc  (w_tc)
  );

  // A done input beats the watchdog in the same cycle.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_ERR: if (start) w_nxt = S_LD;
      S_LD:          w_nxt = S_WAIT_LD;
      S_WAIT_LD: begin
        if (phase.ld_done)   w_nxt = S_XF;
        else if (w_tc)       w_nxt = S_ERR;
      end
      S_XF:          w_nxt = S_WAIT_XF;
      S_WAIT_XF: begin
        if (phase.idct_done) w_nxt = S_ST;
        else if (w_tc)       w_nxt = S_ERR;
      end
      S_ST:          w_nxt = S_WAIT_ST;
      S_WAIT_ST: begin
        if (phase.st_done)   w_nxt = S_NEXT;
        else if (w_tc)       w_nxt = S_ERR;
      end
      S_NEXT:        w_nxt = w_last ? S_FIN : S_LD;
      S_FIN:         w_nxt = S_IDLE;
      default:       w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_blk   <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_go) begin
        r_blk  <= '0;
        r_base <= '0;
      end else if (r_state == S_NEXT && !w_last) begin
        r_blk  <= w_blk_inc;
        r_base <= AW'({w_blk_inc, BLK_SHIFT'(0)});
      end
    end
  end

  assign busy    = !((r_state == S_IDLE) || (r_state == S_ERR));
  assign done    = (r_state == S_FIN);
  assign err     = (r_state == S_ERR);
  assign blk_idx = r_blk;

  assign phase.ld_start   = (r_state == S_LD);
  assign phase.idct_start = (r_state == S_XF);
  assign phase.st_start   = (r_state == S_ST);
  assign phase.ld_base    = r_base;
  assign phase.st_base    = r_base;

endmodule

// File: tb/tb_idct_block_sequencer.sv
// Directed bench: two sequencers (1 and 4 blocks, TIMEOUT=16)
// driven by small auto-responders returning done after a latency.
module tb_idct_block_sequencer;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] err;
  logic [11:0] blk [2];

  logic [1:0] man_ld = 2'b00;
  logic [1:0] man_xf = 2'b00;
  logic [1:0] man_st = 2'b00;
  int  lat [2]      = '{3, 1};
  int  hold_blk [2] = '{-1, -1};
  bit  auto_en [2]  = '{1'b1, 1'b1};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : u
    idct_block_sequencer_if #(.AW(18)) ifc ();

    idct_block_sequencer #(
      .AW(18),
      .NUM_BLOCKS(g == 0 ? 1 : 4),
      .TIMEOUT(16)
    ) dut (
      .clock   (clock),
      .rst_n   (rst_n),
      .start   (start[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .err     (err[g]),
      .blk_idx (blk[g]),
      .phase   (ifc.master)
    );

    logic r_ld = 1'b0;
    logic r_xf = 1'b0;
    logic r_st = 1'b0;
    int   pend = 0;
    int   kind = 0;

    assign ifc.ld_done   = r_ld | man_ld[g];
    assign ifc.idct_done = r_xf | man_xf[g];
    assign ifc.st_done   = r_st | man_st[g];

    always @(negedge clock) begin
      r_ld = 1'b0;
      r_xf = 1'b0;
      r_st = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (kind == 0) r_ld = 1'b1;
          else if (kind == 1) begin
            if (int'(blk[g]) != hold_blk[g]) r_xf = 1'b1;
          end else r_st = 1'b1;
        end
      end
      if (auto_en[g] && rst_n) begin
        if (ifc.ld_start)   begin pend = lat[g]; kind = 0; end
        if (ifc.idct_start) begin pend = lat[g]; kind = 1; end
        if (ifc.st_start)   begin pend = lat[g]; kind = 2; end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  // start is high in cycle 0; returns at the negedge of cycle 1.
  task automatic pulse_start(input int g);
    cyc = 0;
    start[g] = 1'b1;
    step();
    start[g] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_chk++;
    if ({busy, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 000000", {busy, done, err});
    end
    n_chk++;
    if ({blk[0], blk[1]} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_blk: got %0d/%0d, want 0/0", blk[0], blk[1]);
    end
    n_chk++;
    if ({u[0].ifc.ld_start, u[0].ifc.idct_start, u[0].ifc.st_start,
         u[1].ifc.ld_start, u[1].ifc.idct_start, u[1].ifc.st_start} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_starts: a phase start is high, want all 0");
    end
    n_chk++;
    if ({u[1].ifc.ld_base, u[1].ifc.st_base} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_base: got %0d/%0d, want 0/0",
               u[1].ifc.ld_base, u[1].ifc.st_base);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_block();
    int t_xf = -1, t_st = -1, t_done = -1, t_idle = -1;
    int n_done = 0, ovl = 0;
    lat[0] = 3;
    pulse_start(0);
    n_chk++;
    if ({u[0].ifc.ld_start, busy[0], u[0].ifc.ld_base} !== {1'b1, 1'b1, 18'd0}) begin
      n_fail++;
      $display("FAIL single_ld: ld_start=%b busy=%b base=%0d, want 1 1 0",
               u[0].ifc.ld_start, busy[0], u[0].ifc.ld_base);
    end
    repeat (30) begin
      step();
      if (u[0].ifc.idct_start && t_xf < 0) t_xf = cyc;
      if (u[0].ifc.st_start && t_st < 0) t_st = cyc;
      if (done[0]) begin n_done++; t_done = cyc; end
      if (!busy[0] && t_idle < 0) t_idle = cyc;
      if (int'(u[0].ifc.ld_start) + int'(u[0].ifc.idct_start) +
          int'(u[0].ifc.st_start) > 1) ovl++;
    end
    n_chk++;
    if (t_xf != 5 || t_st != 9) begin
      n_fail++;
      $display("FAIL single_order: idct at %0d st at %0d, want 5 and 9", t_xf, t_st);
    end
    n_chk++;
    if (n_done != 1 || t_done != 14) begin
      n_fail++;
      $display("FAIL single_done: %0d pulses at %0d, want 1 at 14", n_done, t_done);
    end
    n_chk++;
    if (t_idle != 15 || ovl != 0) begin
      n_fail++;
      $display("FAIL single_busy: busy fell at %0d overlaps %0d, want 15 and 0",
               t_idle, ovl);
    end
  endtask

  task automatic test_multi_block();
    int n_ld = 0, n_st = 0, n_done = 0, t_done = -1, st_at_done = -1;
    lat[1] = 1;
    pulse_start(1);
    repeat (40) begin
      if (u[1].ifc.ld_start) begin
        n_chk++;
        if (u[1].ifc.ld_base !== 18'(n_ld * 64)) begin
          n_fail++;
          $display("FAIL multi_ld_base: got %0d, want %0d",
                   u[1].ifc.ld_base, n_ld * 64);
        end
        n_ld++;
      end
      if (u[1].ifc.st_start) begin
        n_chk++;
        if (u[1].ifc.st_base !== 18'(n_st * 64)) begin
          n_fail++;
          $display("FAIL multi_st_base: got %0d, want %0d",
                   u[1].ifc.st_base, n_st * 64);
        end
        n_st++;
      end
      if (done[1]) begin n_done++; t_done = cyc; st_at_done = n_st; end
      step();
    end
    n_chk++;
    if (n_ld != 4 || n_st != 4) begin
      n_fail++;
      $display("FAIL multi_count: ld %0d st %0d, want 4 and 4", n_ld, n_st);
    end
    n_chk++;
    if (n_done != 1 || t_done != 29 || st_at_done != 4) begin
      n_fail++;
      $display("FAIL multi_done: %0d pulses at %0d after %0d stores, want 1 at 29 after 4",
               n_done, t_done, st_at_done);
    end
  endtask

  task automatic test_stray();
    int k = 0;
    auto_en[1] = 1'b0;
    cyc = 0;
    man_st[1] = 1'b1;
    step();
    man_st[1] = 1'b0;
    step();
    n_chk++;
    if ({busy[1], u[1].ifc.ld_start, u[1].ifc.idct_start, u[1].ifc.st_start} !== 4'b0) begin
      n_fail++;
      $display("FAIL stray_idle: st_done in idle changed outputs, want all 0");
    end
    pulse_start(1);
    step();
    man_xf[1] = 1'b1;
    step();
    man_xf[1] = 1'b0;
    n_chk++;
    if ({busy[1], u[1].ifc.ld_start, u[1].ifc.idct_start, u[1].ifc.st_start} !== 4'b1000) begin
      n_fail++;
      $display("FAIL stray_wait_ld: got %b, want 1000",
               {busy[1], u[1].ifc.ld_start, u[1].ifc.idct_start, u[1].ifc.st_start});
    end
    man_ld[1] = 1'b1;
    auto_en[1] = 1'b1;
    step();
    man_ld[1] = 1'b0;
    n_chk++;
    if (u[1].ifc.idct_start !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_resume: idct_start=%b, want 1", u[1].ifc.idct_start);
    end
    while (!done[1] && k < 100) begin step(); k++; end
    n_chk++;
    if (done[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_finish: done=%b after %0d cycles, want 1", done[1], k);
    end
    step();
  endtask

  task automatic test_timeout();
    int k = 0, bad = 0;
    lat[1] = 1;
    hold_blk[1] = 1;
    pulse_start(1);
    while (cyc < 26) step();
    n_chk++;
    if ({err[1], busy[1], blk[1]} !== {1'b0, 1'b1, 12'd1}) begin
      n_fail++;
      $display("FAIL timeout_pre: err=%b busy=%b blk=%0d, want 0 1 1",
               err[1], busy[1], blk[1]);
    end
    step();
    n_chk++;
    if ({err[1], busy[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b busy=%b, want 1 0", err[1], busy[1]);
    end
    repeat (5) begin
      step();
      if (!err[1] || busy[1] || u[1].ifc.ld_start ||
          u[1].ifc.idct_start || u[1].ifc.st_start) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL timeout_hold: %0d bad cycles in error state, want 0", bad);
    end
    hold_blk[1] = -1;
    pulse_start(1);
    n_chk++;
    if ({err[1], busy[1], u[1].ifc.ld_start, blk[1]} !== {1'b0, 1'b1, 1'b1, 12'd0}) begin
      n_fail++;
      $display("FAIL timeout_restart: err=%b busy=%b ld=%b blk=%0d, want 0 1 1 0",
               err[1], busy[1], u[1].ifc.ld_start, blk[1]);
    end
    while (!done[1] && k < 100) begin step(); k++; end
    n_chk++;
    if (done[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_finish: done=%b after %0d cycles, want 1", done[1], k);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    lat[1] = 3;
    pulse_start(1);
    while (cyc < 37) step();
    n_chk++;
    if ({blk[1], busy[1], u[1].ifc.st_start} !== {12'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_pre: blk=%0d busy=%b, want 2 1", blk[1], busy[1]);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy[1], done[1], err[1], blk[1], u[1].ifc.ld_start, u[1].ifc.idct_start,
         u[1].ifc.st_start, u[1].ifc.ld_base, u[1].ifc.st_base} !== 54'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: outputs not cleared, busy=%b blk=%0d base=%0d",
               busy[1], blk[1], u[1].ifc.ld_base);
    end
    step();
    rst_n = 1'b1;
    repeat (30) begin
      step();
      if (done[1] || busy[1] || u[1].ifc.ld_start) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d active cycles after reset, want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int n_ld = 0;
    lat[1] = 1;
    pulse_start(1);
    repeat (40) begin
      if (u[1].ifc.ld_start) begin
        n_chk++;
        if (blk[1] !== 12'(n_ld)) begin
          n_fail++;
          $display("FAIL b2b_blk: got %0d, want %0d", blk[1], n_ld);
        end
        n_ld++;
      end
      if (cyc == 29) begin
        n_chk++;
        if (done[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_done: done=%b at cycle 29, want 1", done[1]);
        end
      end
      if (cyc == 30) begin
        n_chk++;
        if (busy[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_fin_start: busy=%b after start in FIN, want 0", busy[1]);
        end
      end
      start[1] = (cyc == 10 || cyc == 29);
      step();
    end
    start[1] = 1'b0;
    n_chk++;
    if (n_ld != 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d loads, want 4", n_ld);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_stray();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/idct_block_sequencer.md
Name: idct_block_sequencer

Overview:
- Controller that runs the inverse-DCT flow over a whole frame, one 8x8 block at a time.
- Per block it runs three phases in order: coefficient load from the 64-bit coefficient memory, the iCDT transform, and the result store into the 32-bit output memory.
- It generates each block's base address, counts blocks, and turns the single frame-level start into per-phase start/done handshakes.
- A per-phase watchdog reports a stuck phase.

Parameters:
- AW, 18, memory address width.
- NUM_BLOCKS, 4096, number of 8x8 blocks per frame (2^AW / 64).
- TIMEOUT, 1024, maximum cycles waiting for any phase done before error.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start pulse.
- busy  out  1  high from accepted start until done/err.
- done  out  1  one-cycle pulse when the last block has been stored.
- err  out  1  sticky watchdog error; held until next accepted start.
- blk_idx  out  12  index of the current block.
- ld_start  out  1  one-cycle pulse that starts the coefficient load.
- ld_base  out  AW  load base address, = blk_idx*64.
- ld_done  in  1  load complete pulse.
- idct_start  out  1  one-cycle pulse that starts the iCDT.
- idct_done  in  1  iCDT complete pulse.
- st_start  out  1  one-cycle pulse that starts the result store.
- st_base  out  AW  store base address, = blk_idx*64.
- st_done  in  1  store complete pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0; blk_idx=0; watchdog counter=0.
- States: IDLE, LD, WAIT_LD, XF, WAIT_XF, ST, WAIT_ST, NEXT, FIN, ERR.
- IDLE: start=1 -> clear blk_idx, clear err, set busy, go to LD.
- LD: assert ld_start for exactly one cycle, go to WAIT_LD.
  - Latency from start to ld_start is 1 cycle.
- WAIT_LD: ld_done=1 -> XF.
- XF: pulse idct_start, go to WAIT_XF.
- WAIT_XF: idct_done=1 -> ST.
- ST: pulse st_start, go to WAIT_ST.
- WAIT_ST: st_done=1 -> NEXT.
- NEXT:
  - If blk_idx==NUM_BLOCKS-1 -> FIN.
  - Else increment blk_idx and go to LD.
- FIN: pulse done for one cycle, clear busy, go to IDLE.
- Address generation:
  - ld_base = st_base = {blk_idx, 6'b0}, truncated to AW bits.
  - Both are registered and stable throughout every state of a block.
- Done-pulse handling:
  - A done input is honoured only in its matching WAIT state.
  - Done pulses arriving in any other state are ignored; they are not queued.
  - If a done input is already high in the cycle its start pulse is issued, it is not counted; the WAIT state requires a done in a later cycle.
- Watchdog:
  - The counter clears on entry to each WAIT state and increments each cycle while waiting.
  - Reaching TIMEOUT -> ERR: err=1, busy=0, no further phase starts.
  - From ERR, start=1 -> clear err and restart at block 0.
  - A done that arrives in the same cycle the counter reaches TIMEOUT wins; no error is raised.
- start while busy=1 is ignored.
- start in the same cycle as FIN is ignored; a new frame needs start while in IDLE.
- rst_n asserted mid-frame aborts immediately; no done pulse is produced.
- Start pulses never overlap: at most one of ld_start, idct_start, st_start is high in any cycle.
- Minimum per-block overhead: 4 controller cycles (LD, XF, ST, NEXT) plus phase latencies.

Decomposition:
- Shared package holds:
  - the state enum;
  - BLK_WORDS=64 and BLK_SHIFT=6;
  - the default NUM_BLOCKS and TIMEOUT.
- One natural sub-module, phase_watchdog: counter with clear, enable and terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Single block, NUM_BLOCKS=1, each done returned 3 cycles after its start:
  - ld_start at cycle 1 after start, with ld_base=0.
  - Order ld_start -> idct_start -> st_start.
  - done pulses once; busy then falls.
- NUM_BLOCKS=4, each done returned 1 cycle after its start:
  - ld_base/st_base step 0, 64, 128, 192.
  - done asserted exactly once, after the 4th st_done.
- Stray pulses: idct_done in WAIT_LD, then st_done in IDLE -> no state change and no spurious start pulses.
- Timeout, TIMEOUT=16, idct_done withheld:
  - err=1 and busy=0 exactly 16 cycles after entering WAIT_XF.
  - A following start clears err and restarts at blk_idx=0.
- rst_n pulsed low during WAIT_ST of block 2 -> all outputs 0 asynchronously, and no done pulse.
- start pulsed while busy at block 1 -> ignored; blk_idx continues 1, 2, ... with no restart.
